// File: rtl/mc_issue_sched.sv
// rtl/mc_issue_sched.sv - EX-stage issue scheduler for multicycle units (mul/div, atomic, FPU)
// Holds the front end while a unit runs, then replays the result into EX/MEM.
module mc_issue_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [1:0] ex_unit,
  input  logic       flush,
  input  logic       mem_stall,
  input  logic       done_md,
  input  logic       done_amo,
  input  logic       done_fp,
  output logic       start_md,
  output logic       start_amo,
  output logic       start_fp,
  output logic       hold_exmem,
  output logic       issue_valid,
  output logic       stall_front,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COMPLETE = 2'd2,
    ABORT    = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] unit_q;
  logic [7:0] cnt;
  logic       mc_req, go, start_any, done_raw, sel_done, wd_hit, timeout_d;

  assign mc_req    = ex_valid && (ex_unit != 2'd0);
  assign go        = (state == IDLE) && mc_req && !flush && !mem_stall;
  assign start_any = start_md | start_amo | start_fp;
  assign wd_hit    = (cnt == 8'(TIMEOUT - 2));
  assign state_dbg = state;

  always_comb begin
    done_raw = 1'b0;
    case (unit_q)
      2'd1:    done_raw = done_md;
      2'd2:    done_raw = done_amo;
      2'd3:    done_raw = done_fp;
      default: done_raw = 1'b0;
    endcase
  end

  // A done still high from the previous operation is stale during the start cycle.
  assign sel_done = done_raw && !start_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (go) state_nxt = BUSY;
      BUSY: begin
        if (flush)         state_nxt = ABORT;
        else if (sel_done) state_nxt = COMPLETE;
        else if (wd_hit)   state_nxt = IDLE;
      end
      COMPLETE: if (flush || !mem_stall) state_nxt = IDLE;
      ABORT:    if (sel_done || wd_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Registered so the pulse lands on the first IDLE cycle after the watchdog gives up.
  assign timeout_d = ((state == BUSY) && !flush && !sel_done && wd_hit) ||
                     ((state == ABORT) && !sel_done && wd_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_q      <= 2'd0;
      cnt         <= 8'd0;
      start_md    <= 1'b0;
      start_amo   <= 1'b0;
      start_fp    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (go) unit_q <= ex_unit;
      if (go || ((state == BUSY) && (state_nxt == ABORT))) cnt <= 8'd0;
      else if ((state == BUSY) || (state == ABORT))         cnt <= cnt + 8'd1;
      start_md    <= go && (ex_unit == 2'd1);
      start_amo   <= go && (ex_unit == 2'd2);
      start_fp    <= go && (ex_unit == 2'd3);
      timeout_err <= timeout_d;
    end
  end

  always_comb begin
    hold_exmem  = 1'b0;
    issue_valid = 1'b0;
    stall_front = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          hold_exmem = mem_stall;
          if (mc_req && !flush) begin
            stall_front = 1'b1;
          end else begin
            issue_valid = ex_valid && !flush && !timeout_err;
            stall_front = mem_stall;
          end
        end
        BUSY:     stall_front = 1'b1;
        COMPLETE: begin
          issue_valid = !flush;
          hold_exmem  = mem_stall;
          stall_front = mem_stall;
        end
        ABORT:    stall_front = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_issue_sched.sv
// tb/tb_mc_issue_sched.sv - directed scoreboard bench for mc_issue_sched
// Expected output vector per cycle: {state, issue, hold, stall, start_fp, start_amo, start_md, timeout_err}.
module tb_mc_issue_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ex_valid = 1'b0;
  logic [1:0] ex_unit = 2'd0;
  logic       flush = 1'b0;
  logic       mem_stall = 1'b0;
  logic       done_md = 1'b0;
  logic       done_amo = 1'b0;
  logic       done_fp = 1'b0;
  logic       start_md, start_amo, start_fp;
  logic       hold_exmem, issue_valid, stall_front, timeout_err;
  logic [1:0] state_dbg;

  int checks = 0;
  int passed = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  localparam logic [2:0] D0 = 3'b000;
  localparam logic [2:0] MD = 3'b001;
  localparam logic [2:0] AM = 3'b010;
  localparam logic [2:0] FP = 3'b100;

  mc_issue_sched #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_unit(ex_unit),
    .flush(flush), .mem_stall(mem_stall),
    .done_md(done_md), .done_amo(done_amo), .done_fp(done_fp),
    .start_md(start_md), .start_amo(start_amo), .start_fp(start_fp),
    .hold_exmem(hold_exmem), .issue_valid(issue_valid), .stall_front(stall_front),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ex(input logic [1:0] st, input logic iv, input logic h,
                                    input logic s, input logic [2:0] sm, input logic te);
    return {st, iv, h, s, sm, te};
  endfunction

  task automatic cyc(input string tag, input logic rs, input logic v, input logic [1:0] u,
                     input logic fl, input logic ms, input logic [2:0] dn, input logic [8:0] e);
    logic [8:0] obs;
    logic [8:0] want;
    string      t;
    @(posedge clk);
    #1;
    reset     = rs;
    ex_valid  = v;
    ex_unit   = u;
    flush     = fl;
    mem_stall = ms;
    {done_fp, done_amo, done_md} = dn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = {state_dbg, issue_valid, hold_exmem, stall_front,
            start_fp, start_amo, start_md, timeout_err};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %b expected %b", t, obs, want);
  endtask

  initial begin
    // reset gating
    cyc("rst0", 1, 1, 0, 0, 0, D0, ex(0,0,0,0,D0,0));
    cyc("rst1", 1, 1, 1, 0, 1, D0, ex(0,0,0,0,D0,0));
    // single-cycle path
    cyc("alu0", 0, 1, 0, 0, 0, D0, ex(0,1,0,0,D0,0));
    cyc("alu1", 0, 1, 0, 0, 0, D0, ex(0,1,0,0,D0,0));
    cyc("alu2", 0, 1, 0, 0, 0, D0, ex(0,1,0,0,D0,0));
    cyc("alu_stall", 0, 1, 0, 0, 1, D0, ex(0,1,1,1,D0,0));
    cyc("alu_flush", 0, 1, 0, 1, 0, D0, ex(0,0,0,0,D0,0));
    // mul/div, done 5 cycles after start (stale done in start cycle, foreign done ignored)
    cyc("md_req", 0, 1, 1, 0, 0, D0, ex(0,0,0,1,D0,0));
    cyc("md_b0",  0, 1, 1, 0, 0, MD, ex(1,0,0,1,MD,0));
    cyc("md_b1",  0, 1, 1, 0, 0, D0, ex(1,0,0,1,D0,0));
    cyc("md_b2",  0, 1, 1, 0, 0, AM, ex(1,0,0,1,D0,0));
    cyc("md_b3",  0, 1, 1, 0, 0, D0, ex(1,0,0,1,D0,0));
    cyc("md_b4",  0, 1, 1, 0, 0, D0, ex(1,0,0,1,D0,0));
    cyc("md_b5",  0, 1, 1, 0, 0, MD, ex(1,0,0,1,D0,0));
    cyc("md_cpl", 0, 1, 1, 0, 0, MD, ex(2,1,0,0,D0,0));
    cyc("md_idle",0, 0, 0, 0, 0, MD, ex(0,0,0,0,D0,0));
    // COMPLETE held by mem_stall
    cyc("s_req", 0, 1, 1, 0, 0, D0, ex(0,0,0,1,D0,0));
    cyc("s_b0",  0, 1, 1, 0, 0, MD, ex(1,0,0,1,MD,0));
    cyc("s_b1",  0, 1, 1, 0, 0, MD, ex(1,0,0,1,D0,0));
    cyc("s_c0",  0, 1, 1, 0, 1, MD, ex(2,1,1,1,D0,0));
    cyc("s_c1",  0, 1, 1, 0, 1, MD, ex(2,1,1,1,D0,0));
    cyc("s_c2",  0, 1, 1, 0, 1, MD, ex(2,1,1,1,D0,0));
    cyc("s_c3",  0, 1, 1, 0, 0, MD, ex(2,1,0,0,D0,0));
    cyc("s_idle",0, 0, 0, 0, 0, D0, ex(0,0,0,0,D0,0));
    // atomic request blocked by mem_stall, then flushed mid-BUSY
    cyc("a_wait0", 0, 1, 2, 0, 1, D0, ex(0,0,1,1,D0,0));
    cyc("a_wait1", 0, 1, 2, 0, 1, D0, ex(0,0,1,1,D0,0));
    cyc("a_req",   0, 1, 2, 0, 0, D0, ex(0,0,0,1,D0,0));
    cyc("a_b0",    0, 1, 2, 0, 0, D0, ex(1,0,0,1,AM,0));
    cyc("a_b1",    0, 1, 2, 0, 0, D0, ex(1,0,0,1,D0,0));
    cyc("a_b2",    0, 1, 2, 1, 0, D0, ex(1,0,0,1,D0,0));
    cyc("a_x0",    0, 0, 0, 0, 0, MD, ex(3,0,0,1,D0,0));
    cyc("a_x1",    0, 0, 0, 0, 0, D0, ex(3,0,0,1,D0,0));
    cyc("a_x2",    0, 0, 0, 0, 0, D0, ex(3,0,0,1,D0,0));
    cyc("a_x3",    0, 0, 0, 0, 0, AM, ex(3,0,0,1,D0,0));
    cyc("a_idle",  0, 0, 0, 0, 0, AM, ex(0,0,0,0,D0,0));
    // flush and done in the same cycle: flush wins
    cyc("f_req",  0, 1, 1, 0, 0, D0, ex(0,0,0,1,D0,0));
    cyc("f_b0",   0, 1, 1, 0, 0, D0, ex(1,0,0,1,MD,0));
    cyc("f_b1",   0, 1, 1, 1, 0, MD, ex(1,0,0,1,D0,0));
    cyc("f_x0",   0, 0, 0, 0, 0, MD, ex(3,0,0,1,D0,0));
    cyc("f_idle", 0, 0, 0, 0, 0, MD, ex(0,0,0,0,D0,0));
    // FPU watchdog with TIMEOUT=8
    cyc("t_req", 0, 1, 3, 0, 0, D0, ex(0,0,0,1,D0,0));
    cyc("t_b0",  0, 1, 3, 0, 0, D0, ex(1,0,0,1,FP,0));
    for (int i = 1; i <= 6; i++)
      cyc($sformatf("t_b%0d", i), 0, 1, 3, 0, 0, D0, ex(1,0,0,1,D0,0));
    cyc("t_err",   0, 1, 0, 0, 0, D0, ex(0,0,0,0,D0,1));
    cyc("t_after", 0, 1, 0, 0, 0, D0, ex(0,1,0,0,D0,0));
    // reset mid-BUSY
    cyc("r_req",  0, 1, 1, 0, 0, D0, ex(0,0,0,1,D0,0));
    cyc("r_b0",   0, 1, 1, 0, 0, D0, ex(1,0,0,1,MD,0));
    cyc("r_rst",  1, 1, 1, 0, 0, D0, ex(0,0,0,0,D0,0));
    cyc("r_rel0", 0, 0, 0, 0, 0, D0, ex(0,0,0,0,D0,0));
    cyc("r_rel1", 0, 0, 0, 0, 0, D0, ex(0,0,0,0,D0,0));
    // reset lands just after a start was registered
    cyc("p_req",  0, 1, 2, 0, 0, D0, ex(0,0,0,1,D0,0));
    cyc("p_rst",  1, 1, 2, 0, 0, D0, ex(0,0,0,0,D0,0));
    cyc("p_rel",  0, 0, 0, 0, 0, D0, ex(0,0,0,0,D0,0));
    cyc("p_rel1", 0, 0, 0, 0, 0, D0, ex(0,0,0,0,D0,0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
